// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator and pixel sink: coordinates out, aligned sync/RGB565 to the DAC.
// Optional VGA_TEST_PATTERN_EN replaces pix_data with an internal 8-bar colour pattern.
module vga_timing_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_REQ_LO = 10'(H_START - 1);
    localparam logic [9:0] H_REQ_HI = 10'(H_START + H_VALID - 1);
    localparam logic [9:0] H_ACT_LO = 10'(H_START);
    localparam logic [9:0] H_ACT_HI = 10'(H_START + H_VALID);
    localparam logic [9:0] V_ACT_LO = 10'(V_START);
    localparam logic [9:0] V_ACT_HI = 10'(V_START + V_VALID);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);

    logic [9:0]  cnt_h;
    logic [9:0]  cnt_v;
    logic        v_win;
    logic        pix_req;
    logic        act;
    logic [15:0] pix_src;

    // Stage p0: raster counters
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    // Request runs one pixel ahead so the generator's registered data lands on the active column
    assign v_win   = (cnt_v >= V_ACT_LO) && (cnt_v < V_ACT_HI);
    assign pix_req = (cnt_h >= H_REQ_LO) && (cnt_h < H_REQ_HI) && v_win;
    assign act     = (cnt_h >= H_ACT_LO) && (cnt_h < H_ACT_HI) && v_win;
    assign pix_x   = pix_req ? (cnt_h - H_REQ_LO) : 10'h3FF;
    assign pix_y   = pix_req ? (cnt_v - V_ACT_LO) : 10'h3FF;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_VALID / 8);

    function automatic logic [15:0] bar_color(input logic [9:0] col);
        case (col / BAR_W)
            10'd0:   bar_color = 16'hFFFF;
            10'd1:   bar_color = 16'hFFE0;
            10'd2:   bar_color = 16'h07FF;
            10'd3:   bar_color = 16'h07E0;
            10'd4:   bar_color = 16'hF81F;
            10'd5:   bar_color = 16'hF800;
            10'd6:   bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    logic unused_pix_data;
    assign unused_pix_data = ^pix_data;
    assign pix_src = bar_color(cnt_h - H_ACT_LO);
`else
    assign pix_src = pix_data;
`endif

    // Stage p1: output register, all DAC-side signals lag the counters by one cycle
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb_valid   <= 1'b0;
            rgb         <= 16'h0000;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !(cnt_h < H_SYNC_W);
            vsync       <= !(cnt_v < V_SYNC_W);
            rgb_valid   <= act;
            rgb         <= act ? pix_src : 16'h0000;
            frame_start <= (cnt_h == 10'd0) && (cnt_v == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl with a shrunken raster (25 x 11) so full frames stay short.
module tb_vga_timing_ctrl;
    localparam int HS = 4, HB = 3, HV = 16, HF = 2;
    localparam int VS = 2, VB = 2, VV = 6, VF = 1;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FRAME = HT * VT;
`ifdef VGA_TEST_PATTERN_EN
    localparam logic [15:0] CONST_VAL = 16'h1234;
`else
    localparam logic [15:0] CONST_VAL = 16'hABCD;
`endif

    logic        vga_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] pix_data = 16'h0000;
    logic [9:0]  pix_x, pix_y;
    logic        hsync, vsync, rgb_valid, frame_start;
    logic [15:0] rgb;

    int errors = 0;
    int checks = 0;
    bit gen_const = 1'b0;
    logic [15:0] sb_q[$];

    vga_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
    ) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
        .rgb_valid(rgb_valid), .rgb(rgb), .frame_start(frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    // Pixel generator model: one register of latency on the requested coordinate
    always @(posedge vga_clk) pix_data <= gen_const ? CONST_VAL : {pix_y[5:0], pix_x};

    function automatic int m_h(int s); return s % HT; endfunction
    function automatic int m_v(int s); return (s / HT) % VT; endfunction
    function automatic bit m_vwin(int s);
        return (m_v(s) >= VS + VB) && (m_v(s) < VS + VB + VV);
    endfunction
    function automatic bit m_req(int s);
        return (m_h(s) >= HS + HB - 1) && (m_h(s) < HS + HB + HV - 1) && m_vwin(s);
    endfunction
    function automatic bit m_act(int s);
        return (m_h(s) >= HS + HB) && (m_h(s) < HS + HB + HV) && m_vwin(s);
    endfunction
    function automatic logic [9:0] m_px(int s);
        return m_req(s) ? 10'(m_h(s) - (HS + HB - 1)) : 10'h3FF;
    endfunction
    function automatic logic [9:0] m_py(int s);
        return m_req(s) ? 10'(m_v(s) - (VS + VB)) : 10'h3FF;
    endfunction
    function automatic logic [15:0] exp_pixel(logic [9:0] x, logic [9:0] y);
`ifdef VGA_TEST_PATTERN_EN
        int b;
        b = int'(x) / (HV / 8);
        case (b)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
`else
        return gen_const ? CONST_VAL : {y[5:0], x};
`endif
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (5) begin
            @(negedge vga_clk);
            checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got=%b exp=1", hsync); end
            checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync got=%b exp=1", vsync); end
            checks++; if (rgb !== 16'h0000) begin errors++; $display("FAIL rst_rgb got=%h exp=0000", rgb); end
            checks++; if (rgb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", rgb_valid); end
            checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
            checks++; if (pix_x !== 10'h3FF) begin errors++; $display("FAIL rst_pix_x got=%h exp=3ff", pix_x); end
            checks++; if (pix_y !== 10'h3FF) begin errors++; $display("FAIL rst_pix_y got=%h exp=3ff", pix_y); end
        end
    endtask

    // Full frame from reset release, every output checked every cycle; pixels via scoreboard
    task automatic test_frame();
        int hs_low, vs_low, val_cnt, so;
        logic [15:0] e;
        hs_low = 0; vs_low = 0; val_cnt = 0;
        sb_q.delete();
        gen_const = 1'b0;
        sys_rst = 1'b0;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge vga_clk);
            so = k - 1;
            if (rgb_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL frame_extra_pixel k=%0d got=%h exp=none", k, rgb);
                end else begin
                    e = sb_q.pop_front();
                    if (rgb !== e) begin errors++; $display("FAIL frame_rgb k=%0d got=%h exp=%h", k, rgb, e); end
                end
            end else begin
                checks++; if (rgb !== 16'h0000) begin errors++; $display("FAIL frame_rgb_blank k=%0d got=%h exp=0000", k, rgb); end
            end
            checks++; if (rgb_valid !== m_act(so)) begin errors++; $display("FAIL frame_valid k=%0d got=%b exp=%b", k, rgb_valid, m_act(so)); end
            checks++; if (hsync !== (m_h(so) >= HS)) begin errors++; $display("FAIL frame_hsync k=%0d got=%b exp=%b", k, hsync, m_h(so) >= HS); end
            checks++; if (vsync !== (m_v(so) >= VS)) begin errors++; $display("FAIL frame_vsync k=%0d got=%b exp=%b", k, vsync, m_v(so) >= VS); end
            checks++; if (frame_start !== (so % FRAME == 0)) begin errors++; $display("FAIL frame_fs k=%0d got=%b exp=%b", k, frame_start, so % FRAME == 0); end
            checks++; if (pix_x !== m_px(k)) begin errors++; $display("FAIL frame_pix_x k=%0d got=%h exp=%h", k, pix_x, m_px(k)); end
            checks++; if (pix_y !== m_py(k)) begin errors++; $display("FAIL frame_pix_y k=%0d got=%h exp=%h", k, pix_y, m_py(k)); end
            if (m_req(k)) sb_q.push_back(exp_pixel(m_px(k), m_py(k)));
            if (k <= FRAME) begin
                if (hsync === 1'b0) hs_low++;
                if (vsync === 1'b0) vs_low++;
                if (rgb_valid === 1'b1) val_cnt++;
            end
        end
        checks++; if (hs_low != HS * VT) begin errors++; $display("FAIL frame_hsync_count got=%0d exp=%0d", hs_low, HS * VT); end
        checks++; if (vs_low != VS * HT) begin errors++; $display("FAIL frame_vsync_count got=%0d exp=%0d", vs_low, VS * HT); end
        checks++; if (val_cnt != HV * VV) begin errors++; $display("FAIL frame_valid_count got=%0d exp=%0d", val_cnt, HV * VV); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL frame_missing_pixels got=%0d exp=0", sb_q.size()); end
    endtask

    // Constant pix_data must only reach rgb inside the active window
    task automatic test_const();
        logic [15:0] e;
        sys_rst = 1'b1;
        sb_q.delete();
        gen_const = 1'b1;
        repeat (2) @(negedge vga_clk);
        sys_rst = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge vga_clk);
            checks++; if (rgb_valid !== m_act(k - 1)) begin errors++; $display("FAIL const_valid k=%0d got=%b exp=%b", k, rgb_valid, m_act(k - 1)); end
            if (rgb_valid === 1'b1 && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++; if (rgb !== e) begin errors++; $display("FAIL const_rgb k=%0d got=%h exp=%h", k, rgb, e); end
            end else if (rgb_valid !== 1'b1) begin
                checks++; if (rgb !== 16'h0000) begin errors++; $display("FAIL const_rgb_blank k=%0d got=%h exp=0000", k, rgb); end
            end
            if (m_req(k)) sb_q.push_back(exp_pixel(m_px(k), m_py(k)));
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL const_missing_pixels got=%0d exp=0", sb_q.size()); end
    endtask

    // Asynchronous reset in the middle of an active line, then a clean restart
    task automatic test_mid_reset();
        int fs_cnt, fs_at;
        fs_cnt = 0; fs_at = -1;
        gen_const = 1'b0;
        sys_rst = 1'b1;
        @(negedge vga_clk);
        sys_rst = 1'b0;
        repeat (5 * HT + 12) @(negedge vga_clk);
        checks++; if (pix_x !== 10'd6) begin errors++; $display("FAIL mid_pre_pix_x got=%h exp=006", pix_x); end
        checks++; if (rgb_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", rgb_valid); end
        sys_rst = 1'b1;
        #1;
        checks++; if (rgb_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", rgb_valid); end
        checks++; if (rgb !== 16'h0000) begin errors++; $display("FAIL mid_rgb got=%h exp=0000", rgb); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL mid_hsync got=%b exp=1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL mid_vsync got=%b exp=1", vsync); end
        checks++; if (pix_x !== 10'h3FF) begin errors++; $display("FAIL mid_pix_x got=%h exp=3ff", pix_x); end
        checks++; if (pix_y !== 10'h3FF) begin errors++; $display("FAIL mid_pix_y got=%h exp=3ff", pix_y); end
        @(negedge vga_clk);
        sys_rst = 1'b0;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge vga_clk);
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 2) fs_at = k;
            end
            if (k == 1) begin
                checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_first_fs got=%b exp=1", frame_start); end
                checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL mid_first_hsync got=%b exp=0", hsync); end
                checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL mid_first_vsync got=%b exp=0", vsync); end
            end
            checks++; if (pix_x !== m_px(k)) begin errors++; $display("FAIL mid_pix_x k=%0d got=%h exp=%h", k, pix_x, m_px(k)); end
        end
        checks++; if (fs_cnt != 2) begin errors++; $display("FAIL mid_fs_count got=%0d exp=2", fs_cnt); end
        checks++; if (fs_at != FRAME + 1) begin errors++; $display("FAIL mid_fs_period got=%0d exp=%0d", fs_at, FRAME + 1); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_const();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
